// File: rtl/trng_ro_ctrl.sv
// trng_ro_ctrl: calibrates the TRNG ring-oscillator stage selects against a target edge count, then samples the ring.
// Define TRNG_RO_CTRL_VN_DEBIAS_EN to pass samples through a von Neumann debiaser before delivery.
module trng_ro_ctrl #(
  parameter int NUM_STAGES    = 5,
  parameter int CNT_W         = 12,
  parameter int WIN_CYCLES    = 256,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_DIV    = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        target_i,
  input  logic                    ro_i,
  output logic                    ro_en_o,
  output logic [3*NUM_STAGES-1:0] sel_o,
  output logic                    busy_o,
  output logic                    cal_done_o,
  output logic                    cal_fail_o,
  output logic                    rng_valid_o,
  output logic                    rng_bit_o,
  input  logic                    rng_ready_i
);

  localparam int PTR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CYC_W = $clog2(WIN_CYCLES + SETTLE_CYCLES + SAMPLE_DIV) + 1;

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, RUN, FAIL} state_e;

  state_e             state_q, state_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ecnt_q, ecnt_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [2:0]         sel_q [NUM_STAGES];
  logic [2:0]         sel_d [NUM_STAGES];
  logic [PTR_W-1:0]   p_q, p_d;
  logic               valid_q, valid_d;
  logic               bit_q, bit_d;
  logic               ro_meta_q, ro_sync_q, ro_prev_q;
  logic               edge_w;
  logic               found, deliver, dbit;
  logic [PTR_W-1:0]   idx, probe;
`ifdef TRNG_RO_CTRL_VN_DEBIAS_EN
  logic               pair_full_q, pair_full_d;
  logic               pair_bit_q, pair_bit_d;
`endif

  // The ring is asynchronous to clk_i: two flops before any use, a third for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ro_meta_q <= 1'b0;
      ro_sync_q <= 1'b0;
      ro_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge value, making this a real shift chain.
      ro_meta_q <= ro_i;
      ro_sync_q <= ro_meta_q;
      ro_prev_q <= ro_sync_q;
    end
  end

  assign edge_w = ro_sync_q & ~ro_prev_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    tgt_d   = tgt_q;
    sel_d   = sel_q;
    p_d     = p_q;
    valid_d = valid_q;
    bit_d   = bit_q;
    found   = 1'b0;
    idx     = p_q;
    probe   = p_q;
    deliver = 1'b0;
    dbit    = 1'b0;
`ifdef TRNG_RO_CTRL_VN_DEBIAS_EN
    pair_full_d = (state_q == RUN) ? pair_full_q : 1'b0;
    pair_bit_d  = pair_bit_q;
`endif

    unique case (state_q)
      SETTLE: begin
        if (cnt_q == CYC_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          ecnt_d  = '0;
          state_d = MEASURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        if (edge_w && (ecnt_q != '1)) ecnt_d = ecnt_q + 1'b1;
        if (cnt_q == CYC_W'(WIN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EVAL: begin
        // Round-robin search from p for the first stage that can still be strengthened.
        for (int k = 0; k < NUM_STAGES; k++) begin
          probe = PTR_W'((int'(p_q) + k) % NUM_STAGES);
          if (!found && (sel_q[probe] != 3'd7)) begin
            found = 1'b1;
            idx   = probe;
          end
        end
        cnt_d = '0;
        if (ecnt_q >= tgt_q) begin
          state_d = RUN;
        end else if (found) begin
          sel_d[idx] = sel_q[idx] + 3'd1;
          p_d        = (idx == PTR_W'(NUM_STAGES - 1)) ? '0 : idx + 1'b1;
          state_d    = SETTLE;
        end else begin
          state_d = FAIL;
        end
      end
      RUN: begin
        if (valid_q && rng_ready_i) valid_d = 1'b0;
        if (cnt_q == CYC_W'(SAMPLE_DIV - 1)) begin
          cnt_d = '0;
`ifdef TRNG_RO_CTRL_VN_DEBIAS_EN
          if (!pair_full_q) begin
            pair_full_d = 1'b1;
            pair_bit_d  = ro_sync_q;
          end else begin
            pair_full_d = 1'b0;
            deliver     = pair_bit_q ^ ro_sync_q;
            dbit        = pair_bit_q;
          end
`else
          deliver = 1'b1;
          dbit    = ro_sync_q;
`endif
          // A candidate that arrives while an unaccepted bit is pending is dropped.
          if (deliver && (!valid_q || rng_ready_i)) begin
            valid_d = 1'b1;
            bit_d   = dbit;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (start_i && (state_q inside {IDLE, RUN, FAIL})) begin
      tgt_d   = target_i;
      sel_d   = '{default: '0};
      p_d     = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = SETTLE;
`ifdef TRNG_RO_CTRL_VN_DEBIAS_EN
      pair_full_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      tgt_q   <= '0;
      // NOTE: the select array is ordinary flops feeding the ring, not a RAM, so it is reset with the rest.
      sel_q   <= '{default: '0};
      p_q     <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
`ifdef TRNG_RO_CTRL_VN_DEBIAS_EN
      pair_full_q <= 1'b0;
      pair_bit_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ecnt_q  <= ecnt_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
`ifdef TRNG_RO_CTRL_VN_DEBIAS_EN
      pair_full_q <= pair_full_d;
      pair_bit_q  <= pair_bit_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_sel
    assign sel_o[3*g +: 3] = sel_q[g];
  end

  assign ro_en_o     = (state_q != IDLE) && (state_q != FAIL);
  assign busy_o      = state_q inside {SETTLE, MEASURE, EVAL};
  assign cal_done_o  = (state_q == RUN);
  assign cal_fail_o  = (state_q == FAIL);
  // A restart pulse in RUN withdraws the pending bit in the same cycle.
  assign rng_valid_o = valid_q & ~start_i;
  assign rng_bit_o   = bit_q;

endmodule

// File: tb/tb_trng_ro_ctrl.sv
// Directed bench for trng_ro_ctrl: reset, calibration timing, select stepping, failure, handshake and sample delivery.
module tb_trng_ro_ctrl;

  localparam int       CAL_CYC = 16 + 256 + 1;
  localparam int       BOUND   = 12000;
  localparam logic [14:0] SEL_STEP = {3'd1, 3'd1, 3'd1, 3'd2, 3'd2};

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [11:0] target_i;
  logic        ro_i;
  logic        ro_en_o;
  logic [14:0] sel_o;
  logic        busy_o;
  logic        cal_done_o;
  logic        cal_fail_o;
  logic        rng_valid_o;
  logic        rng_bit_o;
  logic        rng_ready_i;

  int          n_vec  = 0;
  int          n_miss = 0;

  // Ring model: 0 = constant level, 1 = period-8 square wave, 2 = square wave once the select sum reaches 7.
  int          ro_mode = 0;
  logic        ro_level = 1'b0;
  logic [2:0]  ro_ph = '0;
  int          sel_sum;

  trng_ro_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .target_i    (target_i),
    .ro_i        (ro_i),
    .ro_en_o     (ro_en_o),
    .sel_o       (sel_o),
    .busy_o      (busy_o),
    .cal_done_o  (cal_done_o),
    .cal_fail_o  (cal_fail_o),
    .rng_valid_o (rng_valid_o),
    .rng_bit_o   (rng_bit_o),
    .rng_ready_i (rng_ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) ro_ph <= ro_ph + 3'd1;

  always_comb begin
    sel_sum = 0;
    for (int i = 0; i < 5; i++) sel_sum += int'(sel_o[3*i +: 3]);
  end

  assign ro_i = (ro_mode == 0) ? ro_level :
                ((ro_mode == 1) || (sel_sum >= 7)) ? ro_ph[2] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge after the start pulse where busy_o is low.
  task automatic run_cal(input logic [11:0] tgt, input int poke_at, output int busy_n);
    busy_n   = 0;
    target_i = tgt;
    start_i  = 1'b1;
    #1;
    check("start_masks_valid", {31'd0, rng_valid_o}, 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    check("restart_flags", {29'd0, cal_done_o, cal_fail_o, busy_o}, 32'b001);
    while (busy_o && (busy_n < BOUND)) begin
      busy_n++;
      start_i = (busy_n == poke_at);
      @(negedge clk_i);
    end
    start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   busy_n;
    int   k;
    int   unstable;
    logic samples [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic exp_q [$];
    logic got_q [$];

    rst_ni      = 1'b0;
    start_i     = 1'b0;
    target_i    = '0;
    rng_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_outputs", {11'd0, ro_en_o, sel_o, busy_o, cal_done_o, cal_fail_o, rng_valid_o, rng_bit_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Asynchronous reset in the middle of a measurement window.
    target_i = 12'd10;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (99) @(negedge clk_i);
    check("mid_measure_busy", {31'd0, busy_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_outputs", {11'd0, ro_en_o, sel_o, busy_o, cal_done_o, cal_fail_o, rng_valid_o, rng_bit_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_reset_idle", {15'd0, ro_en_o, busy_o, sel_o}, 32'd0);

    // Fast ring passes on the first window; a start pulse while busy must not restart.
    ro_mode = 1;
    run_cal(12'd10, 100, busy_n);
    check("fast_cal_cycles", busy_n, CAL_CYC);
    check("fast_cal_state", {28'd0, cal_done_o, cal_fail_o, ro_en_o, rng_valid_o}, 32'b1010);
    check("fast_cal_sel", {17'd0, sel_o}, 32'd0);

    // Restart from RUN with a pending bit, using target 0 and a constant-high ring.
    repeat (20) @(negedge clk_i);
    check("run_valid_before_restart", {31'd0, rng_valid_o}, 32'd1);
    ro_mode  = 0;
    ro_level = 1'b1;
    run_cal(12'd0, 0, busy_n);
    check("zero_target_cycles", busy_n, CAL_CYC);
    check("zero_target_done", {31'd0, cal_done_o}, 32'd1);

    k = 0;
    while (!rng_valid_o && (k < 20)) begin
      @(negedge clk_i);
      k++;
    end
    check("first_bit_latency", k, 8);
    check("first_bit_value", {31'd0, rng_bit_o}, 32'd1);

    // Backpressure: later candidates are 0 and must all be dropped.
    ro_level = 1'b0;
    unstable = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (!rng_valid_o || !rng_bit_o) unstable++;
    end
    check("hold_stable", unstable, 0);
    rng_ready_i = 1'b1;
    @(negedge clk_i);
    rng_ready_i = 1'b0;
    check("valid_falls_after_accept", {31'd0, rng_valid_o}, 32'd0);
    repeat (6) @(negedge clk_i);
    check("valid_low_before_tick", {31'd0, rng_valid_o}, 32'd0);
    @(negedge clk_i);
    check("next_bit_at_tick", {30'd0, rng_valid_o, rng_bit_o}, 32'b10);

    // Sample sequence 0,0,0,1,1,0,1,1 with the consumer always ready.
`ifdef TRNG_RO_CTRL_VN_DEBIAS_EN
    for (int i = 0; i < 8; i += 2)
      if (samples[i] != samples[i+1]) exp_q.push_back(samples[i]);
`else
    for (int i = 0; i < 8; i++) exp_q.push_back(samples[i]);
`endif
    rng_ready_i = 1'b1;
    run_cal(12'd0, 0, busy_n);
    check("seq_cal_cycles", busy_n, CAL_CYC);
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk_i);
      if (rng_valid_o) got_q.push_back(rng_bit_o);
      if (((n + 4) % 8 == 0) && (n <= 60)) ro_level = samples[(n + 4) / 8 - 1];
    end
    rng_ready_i = 1'b0;
    check("seq_bit_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("seq_bit_%0d", i), {31'd0, got_q[i]}, {31'd0, exp_q[i]});

    // Stepping: ring only oscillates once the select sum reaches 7.
    ro_mode = 2;
    run_cal(12'd10, 0, busy_n);
    check("step_cycles", busy_n, 8 * CAL_CYC);
    check("step_sel", {17'd0, sel_o}, {17'd0, SEL_STEP});
    check("step_done", {30'd0, cal_done_o, cal_fail_o}, 32'b10);

    // Unreachable target walks all 35 steps and fails.
    ro_mode  = 0;
    ro_level = 1'b0;
    run_cal(12'd4095, 0, busy_n);
    check("fail_cycles", busy_n, 36 * CAL_CYC);
    check("fail_sel", {17'd0, sel_o}, 32'h7fff);
    check("fail_state", {28'd0, cal_done_o, cal_fail_o, ro_en_o, rng_valid_o}, 32'b0100);

    // Restart from FAIL.
    run_cal(12'd0, 0, busy_n);
    check("refail_restart_cycles", busy_n, CAL_CYC);
    check("refail_restart_state", {15'd0, cal_done_o, cal_fail_o, sel_o}, {15'd0, 2'b10, 15'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
